// File: rtl/sequenciador_contagem.sv
// Sequencer that drives the contador_163 clr/ld/enable strobes: one counter step per PRESCALE+1 clocks,
// 15 steps per run. Optional macro SEQ_PAUSA_EN adds a pausa input that freezes the prescaler in ESPERA.
module sequenciador_contagem #(
  parameter int PRESCALE = 1000,
  localparam int PW = $clog2(PRESCALE)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
`ifdef SEQ_PAUSA_EN
  input  logic       pausa,
`endif
  input  logic       rco,
  input  logic       half_rco,
  output logic       zera_n,
  output logic       carrega_n,
  output logic       conta,
  output logic       meio,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    ESPERA  = 4'd2,
    AVANCA  = 4'd3,
    FIM     = 4'd4
  } estado_t;

  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  estado_t       state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          meio_q, meio_d;
  logic          pausa_ativa;

`ifdef SEQ_PAUSA_EN
  assign pausa_ativa = pausa;
`else
  assign pausa_ativa = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INICIAL;
      presc_q <= '0;
      meio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      meio_q  <= meio_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    meio_d    = meio_q;
    zera_n    = 1'b1;
    carrega_n = 1'b1;
    conta     = 1'b0;
    pronto    = 1'b0;
    case (state_q)
      INICIAL: begin
        if (iniciar) state_d = PREPARA;
      end
      PREPARA: begin
        zera_n  = 1'b0;
        presc_d = '0;
        meio_d  = 1'b0;
        state_d = ESPERA;
      end
      ESPERA: begin
        // pausa only ever holds ESPERA, so an AVANCA already under way always completes
        if (!pausa_ativa) begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            state_d = AVANCA;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      AVANCA: begin
        conta = 1'b1;
        if (half_rco) meio_d = 1'b1;
        state_d = rco ? FIM : ESPERA;
      end
      FIM: begin
        pronto  = 1'b1;
        state_d = INICIAL;
      end
      default: state_d = INICIAL;
    endcase
  end

  assign meio      = meio_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_sequenciador_contagem.sv
// Randomized bench: a timing-level model of a run feeds a scoreboard; a monitor checks each
// completion pulse, counter step and half flag against it, with a behavioural contador_163 attached.
module tb_sequenciador_contagem;
  localparam int P      = 4;
  localparam int STEP   = P + 1;
  localparam int RUNLEN = 15 * STEP + 1;   // run-relative cycle of FIM (PREPARA is 0)

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       pausa = 1'b0;
  logic       rco, half_rco;
  logic       zera_n, carrega_n, conta, meio, pronto;
  logic [3:0] db_estado;
  logic [5:0] q = 6'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];          // start cycle of every run issued
  int pause_run = 0;
  int abort_id = 0;
  int started = 0;
  int aborted = 0;
  int done = 0;

  sequenciador_contagem #(.PRESCALE(P)) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
`ifdef SEQ_PAUSA_EN
    .pausa(pausa),
`endif
    .rco(rco),
    .half_rco(half_rco),
    .zera_n(zera_n),
    .carrega_n(carrega_n),
    .conta(conta),
    .meio(meio),
    .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // contador_163 stand-in: sync clear, load of zero, count when ent=enp=1
  assign rco      = conta && (q == 6'd14);
  assign half_rco = conta && (q == 6'd6);
  always @(posedge clock) begin
    if (!zera_n)        q <= 6'd0;
    else if (!carrega_n) q <= 6'd0;
    else if (conta)     q <= q + 6'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // state expected d cycles after the run's PREPARA, counting only unpaused cycles
  function automatic int exp_state(input int d);
    if (d == 0) return 1;
    if (d <= 15 * STEP) return (((d - 1) % STEP) < P) ? 2 : 3;
    if (d == RUNLEN) return 4;
    return 0;
  endfunction

  // monitor / scoreboard
  initial begin
    int conta_cnt = 0;
    int zera_cnt = 0;
    int seen_abort = 0;
    int s;
    forever begin
      @(negedge clock);
      if (seen_abort != abort_id) begin
        seen_abort = abort_id;
        conta_cnt = 0;
        zera_cnt = 0;
      end
      if (!reset) begin
        if (!zera_n) begin
          zera_cnt++;
          conta_cnt = 0;
        end
        if (conta) begin
          conta_cnt++;
          chk("q_at_step", q, conta_cnt - 1);
          chk("meio_at_step", meio, (conta_cnt >= 8) ? 1 : 0);
        end
        if (pronto) begin
          if (exp_q.size() == 0) begin
            chk("pronto_unexpected", 1, 0);
          end else begin
            s = exp_q.pop_front();
            // pronto fills the cycle that ends on edge E+2+15*(P+1); cyc names a cycle by its opening edge
            chk("pronto_cycle", cyc, s + 15 * STEP + 1 + pause_run);
            chk("steps", conta_cnt, 15);
            chk("zera_pulses", zera_cnt, 1);
            chk("q_final", q, 15);
            chk("meio_fim", meio, 1);
            done++;
          end
          zera_cnt = 0;
        end
      end
    end
  end

  // stimulus and timing model
  initial begin
    bit running = 0;
    int d = 0;
    int es;
    int pause_left = 0;
    bit allow;

    repeat (2) @(negedge clock);
    chk("rst_zera_n", zera_n, 1);
    chk("rst_carrega_n", carrega_n, 1);
    chk("rst_conta", conta, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_meio", meio, 0);
    chk("rst_estado", db_estado, 0);
    reset = 1'b0;

    for (int n = 0; n < 1700; n++) begin
      @(negedge clock);
      allow = (n < 1300);
      es = running ? exp_state(d) : 0;
      chk("db_estado", db_estado, es);
      chk("carrega_n", carrega_n, 1);
      if (running && es == 2 && q == 6'd9 && aborted == 0 && started >= 2) begin
        #2 reset = 1'b1;
        #1;
        chk("abort_zera_n", zera_n, 1);
        chk("abort_conta", conta, 0);
        chk("abort_pronto", pronto, 0);
        chk("abort_meio", meio, 0);
        chk("abort_estado", db_estado, 0);
        #1 reset = 1'b0;
        void'(exp_q.pop_back());
        abort_id++;
        aborted++;
        running = 0;
        pause_left = 0;
        iniciar = 1'b0;
        pausa = 1'b0;
      end else begin
        iniciar = ($urandom_range(0, 2) == 0);
        if (!running && !allow) iniciar = 1'b0;
        pausa = 1'b0;
`ifdef SEQ_PAUSA_EN
        if (running && es == 2) begin
          if (pause_left > 0) begin
            pausa = 1'b1;
            pause_left--;
          end else if (pause_run < 30 && $urandom_range(0, 15) == 0) begin
            pause_left = ($urandom_range(0, 1) == 0) ? 10 : $urandom_range(1, 6);
            pausa = 1'b1;
            pause_left--;
          end
        end
`endif
        if (running) begin
          if (es == 4) running = 0;
          else if (es == 2 && pausa) pause_run++;
          else d++;
        end else if (iniciar) begin
          running = 1;
          d = 0;
          pause_run = 0;
          exp_q.push_back(cyc + 1);
          started++;
        end
      end
    end
    iniciar = 1'b0;
    pausa = 1'b0;
    repeat (2) @(negedge clock);
    chk("runs_still_running", int'(running), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("runs_completed", done, started - aborted);
    chk("abort_exercised", aborted, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
